instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: PC_RESET, 32'd0, word-index PC value loaded on reset.
REQ-002 Parameter: NOP_WORD, 32'd0, instruction word injected into IF/ID on bubble or flush.
REQ-003 Parameter: HALT_WORD, 32'hFFFF_FFFF, fetched word that halts fetch when IF_HALT_DETECT_EN is defined.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with ports named as follows.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  asynchronous active-high reset.
- i_stall  in  1  hold PC and IF/ID contents.
- i_branch_taken  in  1  redirect to i_branch_target.
- i_branch_target  in  32  word-index branch target.
- i_jump  in  1  redirect to i_jump_target.
- i_jump_target  in  32  word-index jump target.
- i_instr  in  32  instruction word from instruction memory, valid before each rising edge.
- o_pc  out  32  registered word-index fetch address to instruction memory.
- o_if_id_instr  out  32  latched instruction.
- o_if_id_pc_next  out  32  latched fetch PC + 1.
- o_if_id_valid  out  1  latched instruction is real, not a bubble.
- o_halted  out  1  fetch halted (constant 0 without the macro).

Function
REQ-005 The FSM SHALL have states PRIME, RUN and HALT, with HALT reachable only with IF_HALT_DETECT_EN.
REQ-006 PRIME SHALL be entered on reset and left for RUN on the first rising edge after rst deasserts.
- During that edge: PC is held, o_if_id_instr=NOP_WORD, o_if_id_valid=0, so the memory gets a full cycle to read PC_RESET.
REQ-007 In RUN with no redirect and no stall, each rising edge SHALL update the IF/ID outputs and the PC.
- IF/ID latches {i_instr, o_pc+1, valid=1}.
- o_pc advances to o_pc+1.
- Sustained throughput is one instruction per cycle.
REQ-008 In RUN with i_stall=1 and no redirect, o_pc and all IF/ID outputs SHALL hold.
REQ-009 A redirect in RUN SHALL load the target and flush IF/ID on the next rising edge.
- Redirect means i_branch_taken=1 or i_jump=1.
- o_pc loads the target; o_if_id_instr=NOP_WORD; o_if_id_valid=0.
REQ-010 Redirect SHALL override i_stall in RUN.
REQ-011 When i_branch_taken and i_jump are both 1, the branch target SHALL win, because the branch is the older instruction.
REQ-012 PC arithmetic SHALL be unsigned 32-bit modulo 2^32, so o_pc=32'hFFFF_FFFF advances to 32'h0000_0000 and o_if_id_pc_next wraps the same way.
REQ-013 Fetch-to-IF/ID latency SHALL be one cycle: the word addressed by o_pc during cycle N appears on the IF/ID outputs after edge N.
REQ-014 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-015 Asserting rst SHALL immediately, without waiting for clk, force the following.
- o_pc=PC_RESET, o_if_id_instr=NOP_WORD, o_if_id_pc_next=0, o_if_id_valid=0, o_halted=0, state=PRIME.
REQ-016 Reset asserted mid-operation, including during a stall, redirect or HALT, SHALL discard all pending state with no partial update.
REQ-017 After rst deasserts, the block SHALL behave per REQ-006 before the first real fetch.

Configuration
REQ-018 With macro IF_HALT_DETECT_EN defined, a RUN-state latch SHALL enter HALT when i_instr==HALT_WORD.
- The latch is not stalled and not redirected.
- The halt word latches with valid=1, o_pc holds, o_halted=1 from the next edge.
REQ-019 In HALT, o_pc SHALL hold and every following edge SHALL latch a bubble (NOP_WORD, valid=0).
- A redirect leaves HALT for RUN and loads the target with o_halted=0.
- Otherwise only reset leaves HALT.
REQ-020 Without IF_HALT_DETECT_EN, HALT_WORD SHALL be treated as an ordinary instruction, o_halted SHALL be tied 0, and no HALT state logic SHALL exist.

Verification
REQ-021 Reset, then 3 free-running cycles with memory word(n)=n+0x10.
- Required IF/ID: bubble, then {0x10, pc_next 1, valid}, then {0x11, pc_next 2, valid}.
- Required o_pc sequence: 0, 1, 2.
REQ-022 With o_pc=5, hold i_stall for 2 cycles.
- Required: o_pc=5 and IF/ID unchanged for both cycles, then o_pc=6 after release.
REQ-023 At o_pc=4, assert i_branch_taken=1 (target 20), i_jump=1 (target 40) and i_stall=1 in the same cycle.
- Required: o_pc=20, o_if_id_valid=0, o_if_id_instr=NOP_WORD; next edge latches word(20).
REQ-024 Force o_pc=32'hFFFF_FFFF by jump, then run 1 cycle.
- Required: o_pc=0, o_if_id_pc_next=0.
REQ-025 With the macro defined, memory returns 32'hFFFF_FFFF at address 3.
- Required: o_halted=1, o_pc holds 3, bubbles follow.
- A branch to 0 then resumes fetch with o_halted=0.
- Without the macro the same stimulus yields o_pc=4 and o_halted=0.
REQ-026 Assert rst mid-stall at o_pc=9, away from any clock edge.
- Required: o_pc=0 and o_if_id_valid=0 immediately, and a PRIME bubble after release.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: registered word-index PC plus IF/ID pipeline register.
// Optional halt-word detection is compiled in with `define IF_HALT_DETECT_EN.
module instruction_fetch #(
  parameter logic [31:0] PC_RESET  = 32'd0,
  parameter logic [31:0] NOP_WORD  = 32'd0
`ifdef IF_HALT_DETECT_EN
  ,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_if_id_instr,
  output logic [31:0] o_if_id_pc_next,
  output logic        o_if_id_valid,
  output logic        o_halted
);

  typedef enum logic [1:0] {StPrime, StRun, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_next_q;
  logic        valid_q;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_inc;

  // Branch is the older instruction, so it beats a simultaneous jump.
  assign redirect    = i_branch_taken | i_jump;
  assign redirect_pc = i_branch_taken ? i_branch_target : i_jump_target;
  assign pc_inc      = pc_q + 32'd1;

`ifdef IF_HALT_DETECT_EN
  logic halted_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StPrime;
      pc_q      <= PC_RESET;
      instr_q   <= NOP_WORD;
      pc_next_q <= 32'd0;
      valid_q   <= 1'b0;
`ifdef IF_HALT_DETECT_EN
      halted_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        // One idle edge lets the memory read PC_RESET before the first latch.
        StPrime: begin
          state_q <= StRun;
          instr_q <= NOP_WORD;
          valid_q <= 1'b0;
        end
        StRun: begin
          if (redirect) begin
            pc_q    <= redirect_pc;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
          end else if (!i_stall) begin
            instr_q   <= i_instr;
            pc_next_q <= pc_inc;
            valid_q   <= 1'b1;
`ifdef IF_HALT_DETECT_EN
            if (i_instr == HALT_WORD) begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_inc;
            end
`else
            pc_q <= pc_inc;
`endif
          end
        end
`ifdef IF_HALT_DETECT_EN
        StHalt: begin
          instr_q <= NOP_WORD;
          valid_q <= 1'b0;
          if (redirect) begin
            pc_q     <= redirect_pc;
            state_q  <= StRun;
            halted_q <= 1'b0;
          end
        end
`endif
        default: state_q <= StPrime;
      endcase
    end
  end

  assign o_pc            = pc_q;
  assign o_if_id_instr   = instr_q;
  assign o_if_id_pc_next = pc_next_q;
  assign o_if_id_valid   = valid_q;
`ifdef IF_HALT_DETECT_EN
  assign o_halted        = halted_q;
`else
  assign o_halted        = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized
// redirect/stall traffic compared against a behavioural fetch model.
module tb_instruction_fetch;

  localparam logic [31:0] NOP  = 32'd0;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
`ifdef IF_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br;
  logic [31:0] bt;
  logic        jp;
  logic [31:0] jt;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc_next;
  logic        if_valid;
  logic        halted;
  bit          halt_at3;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pc_next;
  bit          m_valid, m_halted, m_priming;

  instruction_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .i_stall         (stall),
    .i_branch_taken  (br),
    .i_branch_target (bt),
    .i_jump          (jp),
    .i_jump_target   (jt),
    .i_instr         (instr),
    .o_pc            (pc),
    .o_if_id_instr   (if_instr),
    .o_if_id_pc_next (if_pc_next),
    .o_if_id_valid   (if_valid),
    .o_halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] addr, input bit h3);
    if (h3 && addr == 32'd3) return HALT;
    return addr + 32'h10;
  endfunction

  // Instruction memory: combinational read of the DUT's fetch address.
  always_comb instr = mem(pc, halt_at3);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'd0;
    m_instr   = NOP;
    m_pc_next = 32'd0;
    m_valid   = 1'b0;
    m_halted  = 1'b0;
    m_priming = 1'b1;
  endtask

  task automatic model_edge();
    logic [31:0] w;
    logic [31:0] tgt;
    bit          redir;
    redir = br || jp;
    tgt   = br ? bt : jt;
    if (m_priming) begin
      m_priming = 1'b0;
      m_instr   = NOP;
      m_valid   = 1'b0;
    end else if (m_halted) begin
      m_instr = NOP;
      m_valid = 1'b0;
      if (redir) begin
        m_pc     = tgt;
        m_halted = 1'b0;
      end
    end else if (redir) begin
      m_pc    = tgt;
      m_instr = NOP;
      m_valid = 1'b0;
    end else if (!stall) begin
      w         = mem(m_pc, halt_at3);
      m_instr   = w;
      m_pc_next = m_pc + 32'd1;
      m_valid   = 1'b1;
      if (HALT_EN && w == HALT) m_halted = 1'b1;
      else m_pc = m_pc + 32'd1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".instr"}, if_instr, m_instr);
    check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, m_valid});
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
    if (m_valid) check({tag, ".pc_next"}, if_pc_next, m_pc_next);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br = 1'b0; jp = 1'b0;
    bt = 32'd0; jt = 32'd0; halt_at3 = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    check("reset.pc_next", if_pc_next, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Priming bubble then free-running fetch
    step("prime");
    check("prime.pc", pc, 32'd0);
    step("run1");
    check("run1.instr", if_instr, 32'h10);
    check("run1.pc_next", if_pc_next, 32'd1);
    step("run2");
    check("run2.instr", if_instr, 32'h11);
    check("run2.pc", pc, 32'd2);
    repeat (3) step("run");
    check("at5.pc", pc, 32'd5);

    // Stall for two cycles
    stall = 1'b1;
    step("stall1");
    step("stall2");
    check("stall2.pc", pc, 32'd5);
    stall = 1'b0;
    step("unstall");
    check("unstall.pc", pc, 32'd6);

    // Branch + jump + stall together: branch wins, stall ignored
    jp = 1'b1; jt = 32'd4;
    step("jmp4");
    jp = 1'b0;
    br = 1'b1; bt = 32'd20; jp = 1'b1; jt = 32'd40; stall = 1'b1;
    step("brjp");
    check("brjp.pc", pc, 32'd20);
    check("brjp.valid", {31'd0, if_valid}, 32'd0);
    br = 1'b0; jp = 1'b0; stall = 1'b0;
    step("after_br");
    check("after_br.instr", if_instr, 32'h24);

    // PC wrap
    jp = 1'b1; jt = 32'hFFFF_FFFF;
    step("jmp_max");
    jp = 1'b0;
    step("wrap");
    check("wrap.pc", pc, 32'd0);
    check("wrap.pc_next", if_pc_next, 32'd0);

    // Halt word at address 3
    halt_at3 = 1'b1;
    jp = 1'b1; jt = 32'd0;
    step("jmp0");
    jp = 1'b0;
    repeat (4) step("to_halt");
    check("halt.pc", pc, HALT_EN ? 32'd3 : 32'd4);
    check("halt.flag", {31'd0, halted}, {31'd0, HALT_EN});
    repeat (2) step("halted");
    br = 1'b1; bt = 32'd0;
    step("resume");
    br = 1'b0;
    step("resumed");
    check("resumed.halted", {31'd0, halted}, 32'd0);
    halt_at3 = 1'b0;

    // Randomized redirect/stall traffic
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom % 4) == 0;
      br    = ($urandom % 8) == 0;
      jp    = ($urandom % 8) == 0;
      bt    = ($urandom % 16 == 0) ? $urandom : $urandom_range(0, 63);
      jt    = ($urandom % 16 == 0) ? $urandom : $urandom_range(0, 63);
      step("rand");
    end
    stall = 1'b0; br = 1'b0; jp = 1'b0;

    // Asynchronous reset in the middle of a stall
    jp = 1'b1; jt = 32'd9;
    step("jmp9");
    jp = 1'b0; stall = 1'b1;
    step("stall9");
    check("stall9.pc", pc, 32'd9);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.pc", pc, 32'd0);
    @(negedge clk) begin
      rst = 1'b0;
      stall = 1'b0;
    end
    step("reprime");
    check("reprime.valid", {31'd0, if_valid}, 32'd0);
    step("refetch");
    check("refetch.instr", if_instr, 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
